multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 214 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RISC-V datapath: sequences fetch, decode and
// execute states and drives the datapath selects, ALU op and write enables.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       negetive,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       adrsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic [2:0] immsrc,
    output logic [2:0] aluop,
    output logic       illegal
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;
    localparam logic [3:0] JALR1    = 4'd11;
    localparam logic [3:0] LUI      = 4'd12;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    logic [3:0] state;
    logic [3:0] next_state;
    logic [2:0] func_aluop;
    logic       branch_taken;
    logic       pcwrite_raw;
    logic       irwrite_raw;
    logic       regwrite_raw;
    logic       memwrite_raw;
    logic       illegal_raw;
    logic       unused_func7;

    assign unused_func7 = ^{func7[6], func7[4:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= next_state;
    end

    // Subtract is only reachable from register-register ops; immediates never subtract.
    always_comb begin
        func_aluop = ALU_ADD;
        case (func3)
            3'b000:  if (state == EXECR && func7[5]) func_aluop = ALU_SUB;
            3'b111:  func_aluop = ALU_AND;
            3'b110:  func_aluop = ALU_OR;
            3'b010:  func_aluop = ALU_SLT;
            3'b100:  func_aluop = ALU_XOR;
            default: func_aluop = ALU_ADD;
        endcase
    end

    always_comb begin
        case (func3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = !zero;
            3'b100:  branch_taken = negetive;
            3'b101:  branch_taken = !negetive;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_RTYPE:          next_state = EXECR;
                    OP_ITYPE:          next_state = EXECI;
                    OP_BRANCH:         next_state = BRANCH;
                    OP_JAL:            next_state = JAL;
                    OP_JALR:           next_state = JALR1;
                    OP_LUI:            next_state = LUI;
                    default:           next_state = FETCH;
                endcase
            end
            MEMADR:   next_state = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = mem_ready ? FETCH : MEMWRITE;
            EXECR:    next_state = ALUWB;
            EXECI:    next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BRANCH:   next_state = FETCH;
            JAL:      next_state = ALUWB;
            JALR1:    next_state = JAL;
            LUI:      next_state = FETCH;
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        pcwrite_raw  = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        illegal_raw  = 1'b0;
        adrsrc       = 1'b0;
        alusrca      = 2'b00;
        alusrcb      = 2'b00;
        resultsrc    = 2'b00;
        immsrc       = IMM_I;
        aluop        = ALU_ADD;
        case (state)
            FETCH: begin
                alusrcb     = 2'b10;
                resultsrc   = 2'b10;
                pcwrite_raw = mem_ready;
                irwrite_raw = mem_ready;
            end
            DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                immsrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
                    OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: illegal_raw = 1'b0;
                    default:                            illegal_raw = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                immsrc  = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            MEMREAD:  adrsrc = 1'b1;
            MEMWB: begin
                resultsrc    = 2'b01;
                regwrite_raw = 1'b1;
            end
            MEMWRITE: begin
                adrsrc       = 1'b1;
                memwrite_raw = 1'b1;
            end
            EXECR: begin
                alusrca = 2'b10;
                aluop   = func_aluop;
            end
            EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = func_aluop;
            end
            ALUWB:    regwrite_raw = 1'b1;
            BRANCH: begin
                alusrca     = 2'b10;
                aluop       = ALU_SUB;
                pcwrite_raw = branch_taken;
            end
            JAL: begin
                alusrca     = 2'b01;
                alusrcb     = 2'b10;
                pcwrite_raw = 1'b1;
            end
            JALR1: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            LUI: begin
                immsrc       = IMM_U;
                resultsrc    = 2'b11;
                regwrite_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset must silence the enables at once, even though FETCH itself follows mem_ready.
    assign pcwrite  = rst & pcwrite_raw;
    assign irwrite  = rst & irwrite_raw;
    assign regwrite = rst & regwrite_raw;
    assign memwrite = rst & memwrite_raw;
    assign illegal  = rst & illegal_raw;
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle vector table fed
// through an expected-value queue, plus a mid-instruction reset sequence.
module tb_multicycle_controller;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        z;
        logic        n;
        logic        mr;
        logic [17:0] ex;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero;
    logic       negetive;
    logic       mem_ready;
    logic       pcwrite;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [2:0] immsrc;
    logic [2:0] aluop;
    logic       illegal;
    logic [17:0] obs;

    vec_t        vecs[$];
    logic [17:0] exp_q[$];
    string       name_q[$];
    int          compared = 0;
    int          mismatched = 0;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .negetive(negetive), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .irwrite(irwrite), .regwrite(regwrite),
        .memwrite(memwrite), .adrsrc(adrsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .resultsrc(resultsrc), .immsrc(immsrc),
        .aluop(aluop), .illegal(illegal)
    );

    assign obs = {pcwrite, irwrite, regwrite, memwrite, adrsrc, alusrca,
                  alusrcb, resultsrc, immsrc, aluop, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs expected outputs in the same order as obs.
    function automatic logic [17:0] o(input logic pw, input logic iw, input logic rw,
                                      input logic mw, input logic adr, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] rs,
                                      input logic [2:0] imm, input logic [2:0] aop,
                                      input logic ill);
        return {pw, iw, rw, mw, adr, sa, sb, rs, imm, aop, ill};
    endfunction

    function automatic logic [17:0] e_fetch(input logic mr);
        return o(mr, mr, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 0);
    endfunction
    function automatic logic [17:0] e_decode(input logic [2:0] imm, input logic ill);
        return o(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, imm, 3'b000, ill);
    endfunction
    function automatic logic [17:0] e_memadr(input logic [2:0] imm);
        return o(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, imm, 3'b000, 0);
    endfunction
    function automatic logic [17:0] e_execr(input logic [2:0] aop);
        return o(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000, aop, 0);
    endfunction
    function automatic logic [17:0] e_execi(input logic [2:0] aop);
        return o(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, aop, 0);
    endfunction
    function automatic logic [17:0] e_branch(input logic pw);
        return o(pw, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000, 3'b001, 0);
    endfunction

    localparam logic [17:0] E_MEMREAD  = 18'b0000_1_00_00_00_000_000_0;
    localparam logic [17:0] E_MEMWB    = 18'b0010_0_00_00_01_000_000_0;
    localparam logic [17:0] E_MEMWRITE = 18'b0001_1_00_00_00_000_000_0;
    localparam logic [17:0] E_ALUWB    = 18'b0010_0_00_00_00_000_000_0;
    localparam logic [17:0] E_JAL      = 18'b1000_0_01_10_00_000_000_0;
    localparam logic [17:0] E_JALR1    = 18'b0000_0_10_01_00_000_000_0;
    localparam logic [17:0] E_LUI      = 18'b0010_0_00_00_11_100_000_0;

    task automatic add_vec(input string nm, input logic [6:0] vop, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input logic n,
                           input logic mr, input logic [17:0] ex);
        vec_t v;
        v.name = nm; v.op = vop; v.f3 = f3; v.f7 = f7;
        v.z = z; v.n = n; v.mr = mr; v.ex = ex;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        op = v.op; func3 = v.f3; func7 = v.f7;
        zero = v.z; negetive = v.n; mem_ready = v.mr;
        exp_q.push_back(v.ex);
        name_q.push_back(v.name);
    endtask

    task automatic check_output();
        logic [17:0] ex;
        string       nm;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_empty: got %05h with nothing expected", obs);
        end else begin
            ex = exp_q.pop_front();
            nm = name_q.pop_front();
            if (obs !== ex) begin
                mismatched++;
                $display("[TB] FAIL %s: got %05h expected %05h", nm, obs, ex);
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        apply_stimulus(v);
        @(negedge clk);
        check_output();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // R-type / I-type flows: FETCH, DECODE, EXEC, ALUWB.
        add_vec("fetch.wait", OP_RTYPE, 3'b000, 7'h00, 0, 0, 0, e_fetch(0));
        add_vec("add.F",  OP_RTYPE, 3'b000, 7'h00, 0, 0, 1, e_fetch(1));
        add_vec("add.D",  OP_RTYPE, 3'b000, 7'h00, 0, 0, 1, e_decode(3'b010, 0));
        add_vec("add.EX", OP_RTYPE, 3'b000, 7'h00, 0, 0, 1, e_execr(3'b000));
        add_vec("add.WB", OP_RTYPE, 3'b000, 7'h00, 0, 0, 1, E_ALUWB);
        add_vec("sub.F",  OP_RTYPE, 3'b000, 7'h20, 0, 0, 1, e_fetch(1));
        add_vec("sub.D",  OP_RTYPE, 3'b000, 7'h20, 0, 0, 1, e_decode(3'b010, 0));
        add_vec("sub.EX", OP_RTYPE, 3'b000, 7'h20, 0, 0, 1, e_execr(3'b001));
        add_vec("sub.WB", OP_RTYPE, 3'b000, 7'h20, 0, 0, 1, E_ALUWB);
        add_vec("addi.F",  OP_ITYPE, 3'b000, 7'h20, 0, 0, 1, e_fetch(1));
        add_vec("addi.D",  OP_ITYPE, 3'b000, 7'h20, 0, 0, 1, e_decode(3'b010, 0));
        add_vec("addi.EX", OP_ITYPE, 3'b000, 7'h20, 0, 0, 1, e_execi(3'b000));
        add_vec("addi.WB", OP_ITYPE, 3'b000, 7'h20, 0, 0, 1, E_ALUWB);
        add_vec("xori.F",  OP_ITYPE, 3'b100, 7'h00, 0, 0, 1, e_fetch(1));
        add_vec("xori.D",  OP_ITYPE, 3'b100, 7'h00, 0, 0, 1, e_decode(3'b010, 0));
        add_vec("xori.EX", OP_ITYPE, 3'b100, 7'h00, 0, 0, 1, e_execi(3'b101));
        add_vec("xori.WB", OP_ITYPE, 3'b100, 7'h00, 0, 0, 1, E_ALUWB);
        add_vec("and.F",  OP_RTYPE, 3'b111, 7'h00, 0, 0, 1, e_fetch(1));
        add_vec("and.D",  OP_RTYPE, 3'b111, 7'h00, 0, 0, 1, e_decode(3'b010, 0));
        add_vec("and.EX", OP_RTYPE, 3'b111, 7'h00, 0, 0, 1, e_execr(3'b010));
        add_vec("and.WB", OP_RTYPE, 3'b111, 7'h00, 0, 0, 1, E_ALUWB);
        add_vec("ori.F",  OP_ITYPE, 3'b110, 7'h00, 0, 0, 1, e_fetch(1));
        add_vec("ori.D",  OP_ITYPE, 3'b110, 7'h00, 0, 0, 1, e_decode(3'b010, 0));
        add_vec("ori.EX", OP_ITYPE, 3'b110, 7'h00, 0, 0, 1, e_execi(3'b011));
        add_vec("ori.WB", OP_ITYPE, 3'b110, 7'h00, 0, 0, 1, E_ALUWB);
        add_vec("slt.F",  OP_RTYPE, 3'b010, 7'h00, 0, 0, 1, e_fetch(1));
        add_vec("slt.D",  OP_RTYPE, 3'b010, 7'h00, 0, 0, 1, e_decode(3'b010, 0));
        add_vec("slt.EX", OP_RTYPE, 3'b010, 7'h00, 0, 0, 1, e_execr(3'b100));
        add_vec("slt.WB", OP_RTYPE, 3'b010, 7'h00, 0, 0, 1, E_ALUWB);
        // Branches: three cycles each, pcwrite only when taken.
        add_vec("beq.F",  OP_BRANCH, 3'b000, 7'h00, 1, 0, 1, e_fetch(1));
        add_vec("beq.D",  OP_BRANCH, 3'b000, 7'h00, 1, 0, 1, e_decode(3'b010, 0));
        add_vec("beq.BR", OP_BRANCH, 3'b000, 7'h00, 1, 0, 1, e_branch(1));
        add_vec("bne.F",  OP_BRANCH, 3'b001, 7'h00, 1, 0, 1, e_fetch(1));
        add_vec("bne.D",  OP_BRANCH, 3'b001, 7'h00, 1, 0, 1, e_decode(3'b010, 0));
        add_vec("bne.BR", OP_BRANCH, 3'b001, 7'h00, 1, 0, 1, e_branch(0));
        add_vec("bge.F",  OP_BRANCH, 3'b101, 7'h00, 0, 0, 1, e_fetch(1));
        add_vec("bge.D",  OP_BRANCH, 3'b101, 7'h00, 0, 0, 1, e_decode(3'b010, 0));
        add_vec("bge.BR", OP_BRANCH, 3'b101, 7'h00, 0, 0, 1, e_branch(1));
        add_vec("blt.F",  OP_BRANCH, 3'b100, 7'h00, 0, 1, 1, e_fetch(1));
        add_vec("blt.D",  OP_BRANCH, 3'b100, 7'h00, 0, 1, 1, e_decode(3'b010, 0));
        add_vec("blt.BR", OP_BRANCH, 3'b100, 7'h00, 0, 1, 1, e_branch(1));
        add_vec("bltu.F",  OP_BRANCH, 3'b110, 7'h00, 1, 1, 1, e_fetch(1));
        add_vec("bltu.D",  OP_BRANCH, 3'b110, 7'h00, 1, 1, 1, e_decode(3'b010, 0));
        add_vec("bltu.BR", OP_BRANCH, 3'b110, 7'h00, 1, 1, 1, e_branch(0));
        // Load with two memory wait cycles: seven cycles in total.
        add_vec("lw.F",   OP_LOAD, 3'b010, 7'h00, 0, 0, 1, e_fetch(1));
        add_vec("lw.D",   OP_LOAD, 3'b010, 7'h00, 0, 0, 1, e_decode(3'b010, 0));
        add_vec("lw.MA",  OP_LOAD, 3'b010, 7'h00, 0, 0, 1, e_memadr(3'b000));
        add_vec("lw.MR0", OP_LOAD, 3'b010, 7'h00, 0, 0, 0, E_MEMREAD);
        add_vec("lw.MR1", OP_LOAD, 3'b010, 7'h00, 0, 0, 0, E_MEMREAD);
        add_vec("lw.MR2", OP_LOAD, 3'b010, 7'h00, 0, 0, 1, E_MEMREAD);
        add_vec("lw.WB",  OP_LOAD, 3'b010, 7'h00, 0, 0, 1, E_MEMWB);
        add_vec("sw.F",   OP_STORE, 3'b010, 7'h00, 0, 0, 1, e_fetch(1));
        add_vec("sw.D",   OP_STORE, 3'b010, 7'h00, 0, 0, 1, e_decode(3'b010, 0));
        add_vec("sw.MA",  OP_STORE, 3'b010, 7'h00, 0, 0, 1, e_memadr(3'b001));
        add_vec("sw.MW0", OP_STORE, 3'b010, 7'h00, 0, 0, 0, E_MEMWRITE);
        add_vec("sw.MW1", OP_STORE, 3'b010, 7'h00, 0, 0, 1, E_MEMWRITE);
        // Jumps and lui.
        add_vec("jal.F",   OP_JAL, 3'b000, 7'h00, 0, 0, 1, e_fetch(1));
        add_vec("jal.D",   OP_JAL, 3'b000, 7'h00, 0, 0, 1, e_decode(3'b011, 0));
        add_vec("jal.J",   OP_JAL, 3'b000, 7'h00, 0, 0, 1, E_JAL);
        add_vec("jal.WB",  OP_JAL, 3'b000, 7'h00, 0, 0, 1, E_ALUWB);
        add_vec("jalr.F",  OP_JALR, 3'b000, 7'h00, 0, 0, 1, e_fetch(1));
        add_vec("jalr.D",  OP_JALR, 3'b000, 7'h00, 0, 0, 1, e_decode(3'b010, 0));
        add_vec("jalr.J1", OP_JALR, 3'b000, 7'h00, 0, 0, 1, E_JALR1);
        add_vec("jalr.J",  OP_JALR, 3'b000, 7'h00, 0, 0, 1, E_JAL);
        add_vec("jalr.WB", OP_JALR, 3'b000, 7'h00, 0, 0, 1, E_ALUWB);
        add_vec("lui.F",   OP_LUI, 3'b000, 7'h00, 0, 0, 1, e_fetch(1));
        add_vec("lui.D",   OP_LUI, 3'b000, 7'h00, 0, 0, 1, e_decode(3'b010, 0));
        add_vec("lui.U",   OP_LUI, 3'b000, 7'h00, 0, 0, 1, E_LUI);
        // Illegal opcode: one-cycle pulse in DECODE, then back to FETCH.
        add_vec("bad.F",   OP_BAD, 3'b000, 7'h00, 0, 0, 1, e_fetch(1));
        add_vec("bad.D",   OP_BAD, 3'b000, 7'h00, 0, 0, 1, e_decode(3'b010, 1));
        add_vec("bad.next", OP_BAD, 3'b000, 7'h00, 0, 0, 0, e_fetch(0));

        rst = 1'b0; op = OP_RTYPE; func3 = 3'b000; func7 = 7'h00;
        zero = 1'b0; negetive = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back(e_fetch(0));
        name_q.push_back("reset.outputs");
        check_output();
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Reset asserted mid-store must drop memwrite without any clock edge.
        vecs.delete();
        add_vec("rsw.F",  OP_STORE, 3'b010, 7'h00, 0, 0, 1, e_fetch(1));
        add_vec("rsw.D",  OP_STORE, 3'b010, 7'h00, 0, 0, 1, e_decode(3'b010, 0));
        add_vec("rsw.MA", OP_STORE, 3'b010, 7'h00, 0, 0, 1, e_memadr(3'b001));
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
        mem_ready = 1'b0;
        exp_q.push_back(E_MEMWRITE);
        name_q.push_back("rsw.MW");
        @(negedge clk);
        check_output();
        #2;
        rst = 1'b0;
        exp_q.push_back(e_fetch(0));
        name_q.push_back("rsw.async_reset");
        #1;
        check_output();
        mem_ready = 1'b1;
        exp_q.push_back(e_fetch(0));
        name_q.push_back("rsw.reset_gates_fetch");
        #1;
        check_output();
        @(posedge clk);
        #1;
        rst = 1'b1;

        vecs.delete();
        add_vec("post.F",  OP_RTYPE, 3'b000, 7'h00, 0, 0, 1, e_fetch(1));
        add_vec("post.D",  OP_RTYPE, 3'b000, 7'h00, 0, 0, 1, e_decode(3'b010, 0));
        add_vec("post.EX", OP_RTYPE, 3'b000, 7'h00, 0, 0, 1, e_execr(3'b000));
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
